prog_loader: RTL
================

Name: prog_loader

Overview:
- Writer side of the 12-bit instruction memory: receives a framed program image over a byte-wide valid/ready stream and writes 12-bit words into the 64-word instruction memory from address 0 upward.
- Holds the CPU (PC/register file enable) while a load is in progress.
- Reports completion, and reports checksum, framing or timeout errors.

Parameters:
- ADDR_W, 6, instruction memory address width.
- WORD_W, 12, instruction width (fixed 12; the high byte carries bits 11:8).
- DEPTH, 64, maximum words per frame.
- TIMEOUT_CYC, 5_000_000, idle cycles allowed between accepted bytes inside a frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- in_data  in  8  byte from host interface.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept; a byte is transferred when in_valid & in_ready.
- mem_we  out  1  single-cycle write strobe to instruction memory.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  WORD_W  write data.
- cpu_hold  out  1  1 = CPU clock enable must be forced low.
- done  out  1  level: last frame loaded and checksum good.
- error  out  1  level: last frame failed.
- words_loaded  out  7  count of words written in current/last frame.

Behaviour:
- Reset (rst=0, async): state IDLE; in_ready=0 while rst asserted, then 1 from the first clk edge after release; mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0, words_loaded=0, timeout counter=0, checksum=0.
- Frame format: 0xA5 sync, count N, N pairs of {hi, lo}, checksum byte.
  - Count N is in 1..64.
  - hi[7:4] must be 0; hi[3:0] gives word[11:8]; lo gives word[7:0].
  - Checksum is the XOR of the count byte and all data bytes; sync is excluded.
- IDLE: non-0xA5 bytes are accepted and discarded. 0xA5 causes the following, then the state goes to COUNT:
  - cpu_hold←1, done←0, error←0.
  - words_loaded←0, mem_addr←0, checksum←0.
- COUNT: if byte is 0 or >64, go to ERROR; else latch N, checksum^=byte, go to HI.
- HI: if byte[7:4]≠0, go to ERROR; else latch byte[3:0], checksum^=byte, go to LO.
- LO: checksum^=byte, go to WRITE.
- WRITE (one cycle, in_ready=0):
  - mem_we=1, mem_wdata={hi[3:0],lo}, mem_addr=current word index.
  - Next cycle: mem_addr+1, words_loaded+1.
  - If words_loaded+1==N go to CHECK, else go to HI.
- CHECK: byte==checksum: go to IDLE, done←1, cpu_hold←0. Mismatch: go to ERROR.
- ERROR:
  - error=1, cpu_hold=1.
  - Memory is already partially overwritten and is not rolled back.
  - Bytes are accepted; only 0xA5 leaves, restarting as from IDLE (error←0, go to COUNT). Other bytes are discarded.
- Timeout: counter clears on every accepted byte and in IDLE/ERROR. In COUNT/HI/LO/CHECK, reaching TIMEOUT_CYC-1 idle cycles forces ERROR.
- in_ready is 1 in every state except WRITE and reset. Accept is combinational on in_valid & in_ready with one byte per cycle, so there is zero bubble except WRITE.
- mem_we is never asserted outside WRITE, and is asserted exactly N times per good frame.
- A 0xA5 byte inside a frame (COUNT/HI/LO/CHECK) is treated as data, not resync.
- Reset mid-frame: all outputs return to reset values immediately; the partial memory image stays, and cpu_hold drops to 0.
- words_loaded saturates at 64; mem_addr never wraps within a frame because N≤64.

Test Plan:
- Good frame A5,02,01,A3,00,FF,5F:
  - Two mem_we pulses: addr0=0x1A3, addr1=0x0FF.
  - cpu_hold high from the cycle after A5 until the cycle after 5F; then done=1, words_loaded=2.
- Same frame with checksum 0x60: both writes occur, then error=1, done=0, cpu_hold stays 1.
  - Then stream A5,01,00,07,06: addr0=0x007, error=0, done=1, cpu_hold=0.
- Count 0x00 and count 0x41 → ERROR immediately, no mem_we.
- Hi byte 0x12 → ERROR, no mem_we.
- Full 64-word frame with in_valid held 1 continuously:
  - in_ready low exactly one cycle per word.
  - Last write addr=63, words_loaded=64, no address wrap.
- Stall and reset:
  - Stall in_valid for TIMEOUT_CYC (bench overrides to 16) after the count byte → error=1.
  - Assert rst mid-word → all outputs reset asynchronously, cpu_hold=0.
  - Garbage bytes 0x00,0xFF in IDLE → ignored, no state change.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: receives a framed image over a byte stream and writes 12-bit
// words into instruction memory, holding the CPU while a load is in progress.
// Frame: 0xA5, N (1..DEPTH), N x {hi, lo}, XOR checksum of count and data bytes.
module prog_loader #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned WORD_W      = 12,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              error_o,
  output logic [6:0]        words_loaded_o
);

  localparam logic [7:0] SyncByte = 8'hA5;
  localparam logic [7:0] MaxCount = 8'(DEPTH);
  localparam logic [6:0] MaxWords = 7'(DEPTH);
  // Counter only needs to reach TIMEOUT_CYC-1.
  localparam int unsigned TmoW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StHi,
    StLo,
    StWrite,
    StCheck,
    StError
  } state_e;

  state_e              state_q;
  logic                in_ready_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [WORD_W-1:0]   mem_wdata_q;
  logic                cpu_hold_q;
  logic                done_q;
  logic                error_q;
  logic [6:0]          words_q;
  logic [6:0]          count_q;
  logic [3:0]          hi_q;
  logic [7:0]          csum_q;
  logic [TmoW-1:0]     tmo_q;

  logic accept;
  logic timed;
  logic tmo_hit;
  logic last_word;

  assign accept    = in_valid_i & in_ready_q;
  // Inter-byte timeout only applies while a frame is partially received.
  assign timed     = state_q inside {StCount, StHi, StLo, StCheck};
  assign tmo_hit   = timed & ~accept & (tmo_q == TmoLast);
  assign last_word = (words_q + 7'd1) == count_q;

  // Frame-parsing FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      words_q     <= '0;
      count_q     <= '0;
      hi_q        <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
    end else begin
      mem_we_q   <= 1'b0;
      in_ready_q <= 1'b1;

      if (timed && !accept && !tmo_hit) begin
        tmo_q <= tmo_q + TmoW'(1);
      end else begin
        tmo_q <= '0;
      end

      if (tmo_hit) begin
        state_q <= StError;
        error_q <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle, StError: begin
            if (accept && in_data_i == SyncByte) begin
              cpu_hold_q <= 1'b1;
              done_q     <= 1'b0;
              error_q    <= 1'b0;
              words_q    <= '0;
              mem_addr_q <= '0;
              csum_q     <= '0;
              state_q    <= StCount;
            end
          end
          StCount: begin
            if (accept) begin
              if (in_data_i == 8'd0 || in_data_i > MaxCount) begin
                state_q <= StError;
                error_q <= 1'b1;
              end else begin
                count_q <= in_data_i[6:0];
                csum_q  <= csum_q ^ in_data_i;
                state_q <= StHi;
              end
            end
          end
          StHi: begin
            if (accept) begin
              if (in_data_i[7:4] != 4'd0) begin
                state_q <= StError;
                error_q <= 1'b1;
              end else begin
                hi_q    <= in_data_i[3:0];
                csum_q  <= csum_q ^ in_data_i;
                state_q <= StLo;
              end
            end
          end
          StLo: begin
            if (accept) begin
              csum_q      <= csum_q ^ in_data_i;
              mem_wdata_q <= WORD_W'({hi_q, in_data_i});
              mem_we_q    <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= StWrite;
            end
          end
          StWrite: begin
            words_q    <= (words_q == MaxWords) ? words_q : words_q + 7'd1;
            // Hold at the top address so a full frame never wraps to 0.
            mem_addr_q <= (mem_addr_q == '1) ? mem_addr_q : mem_addr_q + ADDR_W'(1);
            state_q    <= last_word ? StCheck : StHi;
          end
          StCheck: begin
            if (accept) begin
              if (in_data_i == csum_q) begin
                done_q     <= 1'b1;
                cpu_hold_q <= 1'b0;
                state_q    <= StIdle;
              end else begin
                error_q <= 1'b1;
                state_q <= StError;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign in_ready_o     = in_ready_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign cpu_hold_o     = cpu_hold_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign words_loaded_o = words_q;

endmodule
